// File: rtl/cnn_layer_accel_fas_core.sv
// cnn_layer_accel_fas_core: Feature-Aggregation Sequencer.
// Accepts a job (start/ack + cfg word), requests a system-memory read, sums
// convolution map + optional residual map + optional bias lane-wise into an
// output FIFO, requests a system-memory write, then signals completion.
//
// Ports:
//   clk_core, rst (sync, active-low)
//   start_FAS / start_FAS_ack, cfg_data[15:0]=num_out_words, [16]=resd_en, [17]=bias_en
//   sys_mem_read_*  / sys_mem_write_* request/ack/in_prog/cmpl handshakes
//   *_wren / *_datain buffer write ports (convMap, resdMap, krnl1x1Bias used; rest reserved)
//   outBuf_fifo_rden / outBuf_fifo_dout (1-cycle read latency)
//   AWP_complete, send_FAS_complete / FAS_complete_ack
//
// Optional macro FAS_SAT_ADD_EN: lane sums saturate to [-32768, 32767];
// without it lane sums wrap modulo 2^16.
//
// FIFO depths are assumed to be powers of two (pointers wrap naturally).

module cnn_layer_accel_fas_core #(
  parameter int unsigned C_LANES      = 8,
  parameter int unsigned C_WORD_WIDTH = 128,
  parameter int unsigned C_MAP_DEPTH  = 64,
  parameter int unsigned C_OUT_DEPTH  = 64
) (
  input  logic                    clk_core,
  input  logic                    rst,
  input  logic                    start_FAS,
  output logic                    start_FAS_ack,
  input  logic [31:0]             cfg_data,
  output logic                    sys_mem_read_req,
  input  logic                    sys_mem_read_req_ack,
  input  logic                    sys_mem_read_in_prog,
  input  logic                    sys_mem_read_cmpl,
  output logic                    sys_mem_write_req,
  input  logic                    sys_mem_write_req_ack,
  input  logic                    sys_mem_write_in_prog,
  input  logic                    sys_mem_write_cmpl,
  input  logic                    trans_fifo_wren,
  input  logic [C_WORD_WIDTH-1:0] trans_fifo_datain,
  input  logic                    convMap_bram_wren,
  input  logic [C_WORD_WIDTH-1:0] convMap_bram_datain,
  input  logic                    resdMap_bram_wren,
  input  logic [C_WORD_WIDTH-1:0] resdMap_bram_datain,
  input  logic                    partMap_bram_wren,
  input  logic [C_WORD_WIDTH-1:0] partMap_bram_datain,
  input  logic                    prevMap_fifo_wren,
  input  logic [C_WORD_WIDTH-1:0] prevMap_fifo_datain,
  input  logic                    krnl1x1_bram_wren,
  input  logic [C_WORD_WIDTH-1:0] krnl1x1_bram_datain,
  input  logic                    krnl1x1Bias_bram_wren,
  input  logic [C_WORD_WIDTH-1:0] krnl1x1Bias_bram_datain,
  input  logic                    outBuf_fifo_rden,
  output logic [C_WORD_WIDTH-1:0] outBuf_fifo_dout,
  input  logic                    AWP_complete,
  output logic                    send_FAS_complete,
  input  logic                    FAS_complete_ack
);

  localparam int unsigned MAP_AW = $clog2(C_MAP_DEPTH);
  localparam int unsigned MAP_CW = MAP_AW + 1;
  localparam int unsigned OUT_AW = $clog2(C_OUT_DEPTH);
  localparam int unsigned OUT_CW = OUT_AW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_PROC    = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_WR_WAIT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]  state, state_next;
  logic        ack_next, rreq_next, wreq_next, cmpl_next;

  logic [15:0] cfg_num;
  logic        cfg_resd_en, cfg_bias_en;
  logic [15:0] bias;
  logic [15:0] out_cnt;

  logic [C_WORD_WIDTH-1:0] conv_mem [C_MAP_DEPTH];
  logic [C_WORD_WIDTH-1:0] resd_mem [C_MAP_DEPTH];
  logic [C_WORD_WIDTH-1:0] out_mem  [C_OUT_DEPTH];
  logic [MAP_AW-1:0] conv_wr, conv_rd, resd_wr, resd_rd;
  logic [MAP_CW-1:0] conv_cnt, resd_cnt;
  logic [OUT_AW-1:0] out_wr, out_rd;
  logic [OUT_CW-1:0] out_fill;

  logic active, dp_active, job_end, produce;
  logic conv_push, conv_pop, resd_push, resd_pop, out_push, out_pop;
  logic [C_WORD_WIDTH-1:0] sum_word;

  // Reserved ports and informational inputs are intentionally not consumed.
  logic unused_ok;
  assign unused_ok = ^{sys_mem_read_in_prog, sys_mem_write_in_prog, cfg_data[31:18],
                       trans_fifo_wren, trans_fifo_datain, partMap_bram_wren, partMap_bram_datain,
                       prevMap_fifo_wren, prevMap_fifo_datain, krnl1x1_bram_wren,
                       krnl1x1_bram_datain, krnl1x1Bias_bram_datain[C_WORD_WIDTH-1:16]};

  // Lane add: 18-bit signed sum of three 16-bit operands, then saturate or wrap.
  function automatic logic [15:0] lane_add(input logic signed [15:0] a,
                                           input logic signed [15:0] b,
                                           input logic signed [15:0] c);
    logic signed [17:0] s;
    s = 18'(a) + 18'(b) + 18'(c);
`ifdef FAS_SAT_ADD_EN
    if (s > 18'sd32767)       return 16'h7fff;
    else if (s < -18'sd32768) return 16'h8000;
    else                      return s[15:0];
`else
    return s[15:0];
`endif
  endfunction

  // Datapath control
  always_comb begin
    active    = (state != S_IDLE);
    dp_active = (state == S_RD_WAIT) || (state == S_PROC);
    job_end   = (state == S_DONE) && send_FAS_complete && FAS_complete_ack;
    produce   = dp_active && (conv_cnt != '0) && (!cfg_resd_en || (resd_cnt != '0)) &&
                (out_fill != OUT_CW'(C_OUT_DEPTH)) && (out_cnt != cfg_num);
    conv_pop  = produce;
    resd_pop  = produce && cfg_resd_en;
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    conv_push = active && convMap_bram_wren && ((conv_cnt != MAP_CW'(C_MAP_DEPTH)) || conv_pop);
    resd_push = active && resdMap_bram_wren && ((resd_cnt != MAP_CW'(C_MAP_DEPTH)) || resd_pop);
    out_push  = produce;
    out_pop   = outBuf_fifo_rden && (out_fill != '0);
  end

  // Lane-wise sum of FIFO heads
  always_comb begin
    sum_word = '0;
    for (int unsigned i = 0; i < C_LANES; i++) begin
      sum_word[16*i +: 16] = lane_add(conv_mem[conv_rd][16*i +: 16],
                                      cfg_resd_en ? resd_mem[resd_rd][16*i +: 16] : 16'h0000,
                                      cfg_bias_en ? bias : 16'h0000);
    end
  end

  // Next-state and registered-output decode; outputs assert one cycle after state entry
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    rreq_next  = 1'b0;
    wreq_next  = 1'b0;
    cmpl_next  = 1'b0;
    case (state)
      S_IDLE:    if (start_FAS) begin
                   state_next = S_RD_REQ;
                   ack_next   = 1'b1;
                 end
      S_RD_REQ:  if (sys_mem_read_req && sys_mem_read_req_ack) state_next = S_RD_WAIT;
                 else rreq_next = 1'b1;
      S_RD_WAIT: if (sys_mem_read_cmpl) state_next = S_PROC;
      S_PROC:    if ((out_cnt == cfg_num) && AWP_complete) state_next = S_WR_REQ;
      S_WR_REQ:  if (sys_mem_write_req && sys_mem_write_req_ack) state_next = S_WR_WAIT;
                 else wreq_next = 1'b1;
      S_WR_WAIT: if (sys_mem_write_cmpl) state_next = S_DONE;
      S_DONE:    if (send_FAS_complete && FAS_complete_ack) state_next = S_IDLE;
                 else cmpl_next = 1'b1;
      default:   state_next = S_IDLE;
    endcase
  end

  // State, outputs, config and counters
  always_ff @(posedge clk_core) begin
    if (!rst) begin
      state             <= S_IDLE;
      start_FAS_ack     <= 1'b0;
      sys_mem_read_req  <= 1'b0;
      sys_mem_write_req <= 1'b0;
      send_FAS_complete <= 1'b0;
      outBuf_fifo_dout  <= '0;
      cfg_num           <= '0;
      cfg_resd_en       <= 1'b0;
      cfg_bias_en       <= 1'b0;
      bias              <= '0;
      out_cnt           <= '0;
      conv_wr <= '0; conv_rd <= '0; conv_cnt <= '0;
      resd_wr <= '0; resd_rd <= '0; resd_cnt <= '0;
      out_wr  <= '0; out_rd  <= '0; out_fill <= '0;
    end else begin
      state             <= state_next;
      start_FAS_ack     <= ack_next;
      sys_mem_read_req  <= rreq_next;
      sys_mem_write_req <= wreq_next;
      send_FAS_complete <= cmpl_next;

      if (state == S_IDLE && start_FAS) begin
        cfg_num     <= cfg_data[15:0];
        cfg_resd_en <= cfg_data[16];
        cfg_bias_en <= cfg_data[17];
      end
      if (active && krnl1x1Bias_bram_wren) bias <= krnl1x1Bias_bram_datain[15:0];

      if (job_end) begin
        out_cnt <= '0;
        conv_wr <= '0; conv_rd <= '0; conv_cnt <= '0;
        resd_wr <= '0; resd_rd <= '0; resd_cnt <= '0;
      end else begin
        if (produce)   out_cnt <= out_cnt + 16'd1;
        if (conv_push) conv_wr <= conv_wr + MAP_AW'(1);
        if (conv_pop)  conv_rd <= conv_rd + MAP_AW'(1);
        if (resd_push) resd_wr <= resd_wr + MAP_AW'(1);
        if (resd_pop)  resd_rd <= resd_rd + MAP_AW'(1);
        conv_cnt <= conv_cnt + MAP_CW'(conv_push) - MAP_CW'(conv_pop);
        resd_cnt <= resd_cnt + MAP_CW'(resd_push) - MAP_CW'(resd_pop);
      end

      // outBuf survives job end; only reset empties it
      if (out_push) out_wr <= out_wr + OUT_AW'(1);
      if (out_pop) begin
        out_rd           <= out_rd + OUT_AW'(1);
        outBuf_fifo_dout <= out_mem[out_rd];
      end
      out_fill <= out_fill + OUT_CW'(out_push) - OUT_CW'(out_pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk_core) begin
    if (conv_push) conv_mem[conv_wr] <= convMap_bram_datain;
    if (resd_push) resd_mem[resd_wr] <= resdMap_bram_datain;
    if (out_push)  out_mem[out_wr]   <= sum_word;
  end

endmodule

// File: tb/tb_cnn_layer_accel_fas_core.sv
// Self-checking bench for cnn_layer_accel_fas_core: randomized and directed
// jobs checked against a lane-arithmetic reference model.
// Honours FAS_SAT_ADD_EN in the reference model.

module tb_cnn_layer_accel_fas_core;

  localparam int LANES = 8;
  localparam int W     = 128;
  localparam int ODEP  = 64;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic rst;
  logic start_FAS, start_FAS_ack;
  logic [31:0] cfg_data;
  logic sys_mem_read_req, sys_mem_read_req_ack, sys_mem_read_in_prog, sys_mem_read_cmpl;
  logic sys_mem_write_req, sys_mem_write_req_ack, sys_mem_write_in_prog, sys_mem_write_cmpl;
  logic trans_fifo_wren, convMap_bram_wren, resdMap_bram_wren, partMap_bram_wren;
  logic prevMap_fifo_wren, krnl1x1_bram_wren, krnl1x1Bias_bram_wren;
  logic [W-1:0] trans_fifo_datain, convMap_bram_datain, resdMap_bram_datain, partMap_bram_datain;
  logic [W-1:0] prevMap_fifo_datain, krnl1x1_bram_datain, krnl1x1Bias_bram_datain;
  logic outBuf_fifo_rden;
  logic [W-1:0] outBuf_fifo_dout;
  logic AWP_complete, send_FAS_complete, FAS_complete_ack;

  cnn_layer_accel_fas_core dut (
    .clk_core(clk_core), .rst(rst),
    .start_FAS(start_FAS), .start_FAS_ack(start_FAS_ack), .cfg_data(cfg_data),
    .sys_mem_read_req(sys_mem_read_req), .sys_mem_read_req_ack(sys_mem_read_req_ack),
    .sys_mem_read_in_prog(sys_mem_read_in_prog), .sys_mem_read_cmpl(sys_mem_read_cmpl),
    .sys_mem_write_req(sys_mem_write_req), .sys_mem_write_req_ack(sys_mem_write_req_ack),
    .sys_mem_write_in_prog(sys_mem_write_in_prog), .sys_mem_write_cmpl(sys_mem_write_cmpl),
    .trans_fifo_wren(trans_fifo_wren), .trans_fifo_datain(trans_fifo_datain),
    .convMap_bram_wren(convMap_bram_wren), .convMap_bram_datain(convMap_bram_datain),
    .resdMap_bram_wren(resdMap_bram_wren), .resdMap_bram_datain(resdMap_bram_datain),
    .partMap_bram_wren(partMap_bram_wren), .partMap_bram_datain(partMap_bram_datain),
    .prevMap_fifo_wren(prevMap_fifo_wren), .prevMap_fifo_datain(prevMap_fifo_datain),
    .krnl1x1_bram_wren(krnl1x1_bram_wren), .krnl1x1_bram_datain(krnl1x1_bram_datain),
    .krnl1x1Bias_bram_wren(krnl1x1Bias_bram_wren), .krnl1x1Bias_bram_datain(krnl1x1Bias_bram_datain),
    .outBuf_fifo_rden(outBuf_fifo_rden), .outBuf_fifo_dout(outBuf_fifo_dout),
    .AWP_complete(AWP_complete), .send_FAS_complete(send_FAS_complete),
    .FAS_complete_ack(FAS_complete_ack)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] conv_w [128];
  logic [W-1:0] resd_w [128];
  logic [W-1:0] out_w  [128];
  logic [W-1:0] last_dout;

  // Same 16-bit value in every lane.
  function automatic logic [W-1:0] splat(input logic [15:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference lane arithmetic using plain integers.
  function automatic logic [W-1:0] exp_word(input logic [W-1:0] c, input logic [W-1:0] rr,
                                            input bit r, input bit b, input logic [15:0] bs);
    logic [W-1:0] res;
    int s;
    for (int i = 0; i < LANES; i++) begin
      s = int'($signed(c[16*i +: 16]));
      if (r) s = s + int'($signed(rr[16*i +: 16]));
      if (b) s = s + int'($signed(bs));
`ifdef FAS_SAT_ADD_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      res[16*i +: 16] = 16'(s);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic begin_job(input int num, input bit r, input bit b);
    cfg_data  = {14'd0, b, r, 16'(num)};
    start_FAS = 1'b1;
    tick();
    start_FAS = 1'b0;
    tick();
    sys_mem_read_req_ack = 1'b1;
    tick();
    sys_mem_read_req_ack = 1'b0;
  endtask

  task automatic push_maps(input int num, input bit r);
    for (int i = 0; i < num; i++) begin
      convMap_bram_wren   = 1'b1;
      convMap_bram_datain = conv_w[i];
      resdMap_bram_wren   = r;
      resdMap_bram_datain = resd_w[i];
      tick();
    end
    convMap_bram_wren = 1'b0;
    resdMap_bram_wren = 1'b0;
  endtask

  // Completes the read phase and waits (bounded) for the write request.
  task automatic finish_read();
    int k = 0;
    sys_mem_read_cmpl = 1'b1;
    tick();
    sys_mem_read_cmpl = 1'b0;
    AWP_complete = 1'b1;
    while (!sys_mem_write_req && k < 400) begin
      tick();
      k++;
    end
    checks++;
    if (sys_mem_write_req !== 1'b1) begin
      errors++;
      $display("FAIL write_req_wait got=%b exp=1", sys_mem_write_req);
    end
  endtask

  task automatic finish_write();
    int k = 0;
    AWP_complete = 1'b0;
    sys_mem_write_req_ack = 1'b1;
    tick();
    sys_mem_write_req_ack = 1'b0;
    sys_mem_write_cmpl = 1'b1;
    tick();
    sys_mem_write_cmpl = 1'b0;
    while (!send_FAS_complete && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (send_FAS_complete !== 1'b1) begin
      errors++;
      $display("FAIL complete_wait got=%b exp=1", send_FAS_complete);
    end
    FAS_complete_ack = 1'b1;
    tick();
    FAS_complete_ack = 1'b0;
  endtask

  task automatic read_n(input int first, input int n);
    outBuf_fifo_rden = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      out_w[first+i] = outBuf_fifo_dout;
      last_dout = outBuf_fifo_dout;
    end
    outBuf_fifo_rden = 1'b0;
  endtask

  task automatic run_job(input int num, input bit r, input bit b, input logic [15:0] bs);
    begin_job(num, r, b);
    if (b) begin
      krnl1x1Bias_bram_wren   = 1'b1;
      krnl1x1Bias_bram_datain = W'(bs);
      tick();
      krnl1x1Bias_bram_wren = 1'b0;
    end
    push_maps(num, r);
    finish_read();
    read_n(0, num);
    finish_write();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks += 5;
    if (start_FAS_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", start_FAS_ack); end
    if (sys_mem_read_req !== 1'b0) begin errors++; $display("FAIL reset_rreq got=%b exp=0", sys_mem_read_req); end
    if (sys_mem_write_req !== 1'b0) begin errors++; $display("FAIL reset_wreq got=%b exp=0", sys_mem_write_req); end
    if (send_FAS_complete !== 1'b0) begin errors++; $display("FAIL reset_cmpl got=%b exp=0", send_FAS_complete); end
    if (outBuf_fifo_dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", outBuf_fifo_dout); end
    last_dout = '0;
  endtask

  task automatic test_handshake();
    cfg_data  = 32'd2;
    start_FAS = 1'b1;
    tick();
    start_FAS = 1'b0;
    checks += 2;
    if (start_FAS_ack !== 1'b1) begin errors++; $display("FAIL hs_ack_pulse got=%b exp=1", start_FAS_ack); end
    if (sys_mem_read_req !== 1'b0) begin errors++; $display("FAIL hs_rreq_early got=%b exp=0", sys_mem_read_req); end
    tick();
    checks += 2;
    if (start_FAS_ack !== 1'b0) begin errors++; $display("FAIL hs_ack_width got=%b exp=0", start_FAS_ack); end
    if (sys_mem_read_req !== 1'b1) begin errors++; $display("FAIL hs_rreq got=%b exp=1", sys_mem_read_req); end
    tick();
    checks++;
    if (sys_mem_read_req !== 1'b1) begin errors++; $display("FAIL hs_rreq_hold got=%b exp=1", sys_mem_read_req); end
    sys_mem_read_req_ack = 1'b1;
    tick();
    sys_mem_read_req_ack = 1'b0;
    checks++;
    if (sys_mem_read_req !== 1'b0) begin errors++; $display("FAIL hs_rreq_drop got=%b exp=0", sys_mem_read_req); end
    conv_w[0] = splat(16'd5);
    conv_w[1] = splat(16'd7);
    push_maps(2, 1'b0);
    finish_read();
    read_n(0, 2);
    checks += 2;
    if (out_w[0] !== splat(16'd5)) begin errors++; $display("FAIL hs_word0 got=%h exp=%h", out_w[0], splat(16'd5)); end
    if (out_w[1] !== splat(16'd7)) begin errors++; $display("FAIL hs_word1 got=%h exp=%h", out_w[1], splat(16'd7)); end
    AWP_complete = 1'b0;
    sys_mem_write_req_ack = 1'b1;
    tick();
    sys_mem_write_req_ack = 1'b0;
    checks++;
    if (sys_mem_write_req !== 1'b0) begin errors++; $display("FAIL hs_wreq_drop got=%b exp=0", sys_mem_write_req); end
    sys_mem_write_cmpl = 1'b1;
    tick();
    sys_mem_write_cmpl = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (send_FAS_complete !== 1'b1) begin errors++; $display("FAIL hs_cmpl_hold got=%b exp=1", send_FAS_complete); end
    FAS_complete_ack = 1'b1;
    tick();
    FAS_complete_ack = 1'b0;
    tick();
    checks++;
    if (send_FAS_complete !== 1'b0) begin errors++; $display("FAIL hs_cmpl_drop got=%b exp=0", send_FAS_complete); end
  endtask

  task automatic test_resd_bias();
    conv_w[0] = splat(16'd10);
    resd_w[0] = splat(16'hfffc);
    run_job(1, 1'b1, 1'b1, 16'd3);
    checks++;
    if (out_w[0] !== splat(16'd9)) begin errors++; $display("FAIL resd_bias got=%h exp=%h", out_w[0], splat(16'd9)); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] e0, e1;
    conv_w[0] = splat(16'd30000);
    resd_w[0] = splat(16'd10000);
    conv_w[1] = splat(16'(-30000));
    resd_w[1] = splat(16'(-10000));
`ifdef FAS_SAT_ADD_EN
    e0 = splat(16'h7fff);
    e1 = splat(16'h8000);
`else
    e0 = splat(16'(-25536));
    e1 = splat(16'd25536);
`endif
    run_job(2, 1'b1, 1'b0, 16'd0);
    checks += 2;
    if (out_w[0] !== e0) begin errors++; $display("FAIL sat_pos got=%h exp=%h", out_w[0], e0); end
    if (out_w[1] !== e1) begin errors++; $display("FAIL sat_neg got=%h exp=%h", out_w[1], e1); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++) begin
      int num = $urandom_range(1, 12);
      bit r = 1'($urandom);
      bit b = 1'($urandom);
      logic [15:0] bs = 16'($urandom);
      for (int i = 0; i < num; i++) begin
        conv_w[i] = rand_word();
        resd_w[i] = rand_word();
      end
      run_job(num, r, b, bs);
      for (int i = 0; i < num; i++) begin
        logic [W-1:0] e = exp_word(conv_w[i], resd_w[i], r, b, bs);
        checks++;
        if (out_w[i] !== e) begin
          errors++;
          $display("FAIL rand_job%0d_word%0d got=%h exp=%h", j, i, out_w[i], e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int num = ODEP + 4;
    for (int i = 0; i < num; i++) conv_w[i] = rand_word();
    begin_job(num, 1'b0, 1'b0);
    push_maps(num, 1'b0);
    sys_mem_read_cmpl = 1'b1;
    tick();
    sys_mem_read_cmpl = 1'b0;
    AWP_complete = 1'b1;
    repeat (10) tick();
    checks++;
    if (sys_mem_write_req !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", sys_mem_write_req); end
    read_n(0, 4);
    finish_read();
    read_n(4, ODEP);
    for (int i = 0; i < num; i++) begin
      logic [W-1:0] e = exp_word(conv_w[i], '0, 1'b0, 1'b0, 16'd0);
      checks++;
      if (out_w[i] !== e) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, out_w[i], e); end
    end
    finish_write();
    outBuf_fifo_rden = 1'b1;
    tick();
    outBuf_fifo_rden = 1'b0;
    checks++;
    if (outBuf_fifo_dout !== last_dout) begin errors++; $display("FAIL bp_empty_read got=%h exp=%h", outBuf_fifo_dout, last_dout); end
  endtask

  task automatic test_reset_midjob();
    begin_job(1, 1'b0, 1'b0);
    conv_w[0] = splat(16'h00aa);
    push_maps(1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks += 5;
    if (start_FAS_ack !== 1'b0) begin errors++; $display("FAIL mid_ack got=%b exp=0", start_FAS_ack); end
    if (sys_mem_read_req !== 1'b0) begin errors++; $display("FAIL mid_rreq got=%b exp=0", sys_mem_read_req); end
    if (sys_mem_write_req !== 1'b0) begin errors++; $display("FAIL mid_wreq got=%b exp=0", sys_mem_write_req); end
    if (send_FAS_complete !== 1'b0) begin errors++; $display("FAIL mid_cmpl got=%b exp=0", send_FAS_complete); end
    if (outBuf_fifo_dout !== '0) begin errors++; $display("FAIL mid_dout got=%h exp=0", outBuf_fifo_dout); end
    outBuf_fifo_rden = 1'b1;
    tick();
    outBuf_fifo_rden = 1'b0;
    checks++;
    if (outBuf_fifo_dout !== '0) begin errors++; $display("FAIL mid_empty_read got=%h exp=0", outBuf_fifo_dout); end
    last_dout = '0;
    cfg_data  = 32'd1;
    start_FAS = 1'b1;
    tick();
    start_FAS = 1'b0;
    checks++;
    if (start_FAS_ack !== 1'b1) begin errors++; $display("FAIL mid_restart_ack got=%b exp=1", start_FAS_ack); end
    tick();
    sys_mem_read_req_ack = 1'b1;
    tick();
    sys_mem_read_req_ack = 1'b0;
    conv_w[0] = rand_word();
    push_maps(1, 1'b0);
    finish_read();
    read_n(0, 1);
    checks++;
    if (out_w[0] !== conv_w[0]) begin errors++; $display("FAIL mid_restart_word got=%h exp=%h", out_w[0], conv_w[0]); end
    finish_write();
  endtask

  task automatic test_idle_writes();
    logic [W-1:0] fresh;
    conv_w[0] = splat(16'h1234);
    push_maps(1, 1'b0);
    begin_job(1, 1'b0, 1'b0);
    repeat (4) tick();
    outBuf_fifo_rden = 1'b1;
    tick();
    outBuf_fifo_rden = 1'b0;
    checks++;
    if (outBuf_fifo_dout !== last_dout) begin errors++; $display("FAIL idle_drop got=%h exp=%h", outBuf_fifo_dout, last_dout); end
    fresh = rand_word();
    conv_w[0] = fresh;
    push_maps(1, 1'b0);
    finish_read();
    read_n(0, 1);
    checks++;
    if (out_w[0] !== fresh) begin errors++; $display("FAIL idle_fresh got=%h exp=%h", out_w[0], fresh); end
    finish_write();
  endtask

  initial begin
    rst = 1'b1; start_FAS = 1'b0; cfg_data = '0;
    sys_mem_read_req_ack = 1'b0; sys_mem_read_in_prog = 1'b0; sys_mem_read_cmpl = 1'b0;
    sys_mem_write_req_ack = 1'b0; sys_mem_write_in_prog = 1'b0; sys_mem_write_cmpl = 1'b0;
    trans_fifo_wren = 1'b0; convMap_bram_wren = 1'b0; resdMap_bram_wren = 1'b0;
    partMap_bram_wren = 1'b0; prevMap_fifo_wren = 1'b0; krnl1x1_bram_wren = 1'b0;
    krnl1x1Bias_bram_wren = 1'b0;
    trans_fifo_datain = '0; convMap_bram_datain = '0; resdMap_bram_datain = '0;
    partMap_bram_datain = '0; prevMap_fifo_datain = '0; krnl1x1_bram_datain = '0;
    krnl1x1Bias_bram_datain = '0;
    outBuf_fifo_rden = 1'b0; AWP_complete = 1'b0; FAS_complete_ack = 1'b0;
    last_dout = '0;

    test_reset();
    test_handshake();
    test_resd_bias();
    test_saturation();
    test_random();
    test_backpressure();
    test_reset_midjob();
    test_idle_writes();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
